// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator that produces pixel coordinates, syncs, an active-video flag and line/frame start pulses.
// Latency: every output is registered on the same edge as x_o/y_o, so all outputs describe the coordinate currently shown.
// Backpressure: Enable_i=0 freezes the divider, counters and outputs, and holds line_start_o/frame_start_o at 0.
// Ports: clk_i, rst_i (async, active-high), Enable_i in; x_o/y_o [CNT_W] coordinates; h_sync_o, v_sync_o, active_o,
//        line_start_o, frame_start_o out.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DIV      = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Enable_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             active_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A one-bit divider is kept even for DIV=1; it simply never leaves 0.
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_d;
  logic             tick;
  logic             line_wrap;
  logic             frame_wrap;
  logic             hs_d;
  logic             vs_d;
  logic             act_d;

  // Next divider/counter values. A tick needs Enable_i high in the same
  // cycle, so dropping enable on the terminal divider count defers the tick.
  always_comb begin
    tick       = Enable_i && (div_q == DIV_LAST);
    div_d      = div_q;
    x_d        = x_o;
    y_d        = y_o;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (Enable_i) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (x_o == H_LAST) begin
        x_d       = '0;
        line_wrap = 1'b1;
        if (y_o == V_LAST) begin
          y_d        = '0;
          frame_wrap = 1'b1;
        end else begin
          y_d = y_o + 1'b1;
        end
      end else begin
        x_d = x_o + 1'b1;
      end
    end
  end

  // Decode from the next coordinates so the registered flags line up with
  // the registered x_o/y_o without an extra pipeline stage.
  always_comb begin
    hs_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    act_d = (x_d < H_ACT) && (y_d < V_ACT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q         <= '0;
      x_o           <= '0;
      y_o           <= '0;
      h_sync_o      <= ~HS_POL;
      v_sync_o      <= ~VS_POL;
      active_o      <= 1'b1;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (Enable_i) begin
      div_q         <= div_d;
      x_o           <= x_d;
      y_o           <= y_d;
      h_sync_o      <= hs_d;
      v_sync_o      <= vs_d;
      active_o      <= act_d;
      // Pulses come only from a wrap, so the reset-entered (0,0) gives none
      // and the pulse lasts one clock even though x_o sits at 0 for DIV clocks.
      line_start_o  <= line_wrap;
      frame_start_o <= frame_wrap;
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_def, en_small, en_mid;

  logic [9:0] x_def, y_def;
  logic       h_def, v_def, a_def, ls_def, fs_def;
  logic [3:0] x_sm, y_sm;
  logic       h_sm, v_sm, a_sm, ls_sm, fs_sm;
  logic [9:0] x_mid, y_mid;
  logic       h_mid, v_mid, a_mid, ls_mid, fs_mid;

  int checks = 0;
  int passes = 0;

  vga_timing_gen u_def (
    .clk_i(clk), .rst_i(rst), .Enable_i(en_def),
    .x_o(x_def), .y_o(y_def), .h_sync_o(h_def), .v_sync_o(v_def),
    .active_o(a_def), .line_start_o(ls_def), .frame_start_o(fs_def)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .DIV(1), .CNT_W(4)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .Enable_i(en_small),
    .x_o(x_sm), .y_o(y_sm), .h_sync_o(h_sm), .v_sync_o(v_sm),
    .active_o(a_sm), .line_start_o(ls_sm), .frame_start_o(fs_sm)
  );

  // Short lines with the default vertical timing keep a whole frame cheap.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) u_mid (
    .clk_i(clk), .rst_i(rst), .Enable_i(en_mid),
    .x_o(x_mid), .y_o(y_mid), .h_sync_o(h_mid), .v_sync_o(v_mid),
    .active_o(a_mid), .line_start_o(ls_mid), .frame_start_o(fs_mid)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_def = 1'b1; en_small = 1'b1; en_mid = 1'b1;
    #1;
    @(negedge clk);
    checks++;
    if ({x_def, y_def, h_def, v_def, a_def, ls_def, fs_def} !== {10'd0, 10'd0, 5'b11100})
      $display("FAIL reset_def got=%h exp=%h", {x_def, y_def, h_def, v_def, a_def, ls_def, fs_def}, {10'd0, 10'd0, 5'b11100});
    else passes++;
    checks++;
    if ({x_sm, y_sm, h_sm, v_sm, a_sm, ls_sm, fs_sm} !== {4'd0, 4'd0, 5'b01100})
      $display("FAIL reset_small got=%h exp=%h", {x_sm, y_sm, h_sm, v_sm, a_sm, ls_sm, fs_sm}, {4'd0, 4'd0, 5'b01100});
    else passes++;
    checks++;
    if ({x_mid, y_mid, h_mid, v_mid, a_mid, ls_mid, fs_mid} !== {10'd0, 10'd0, 5'b11100})
      $display("FAIL reset_mid got=%h exp=%h", {x_mid, y_mid, h_mid, v_mid, a_mid, ls_mid, fs_mid}, {10'd0, 10'd0, 5'b11100});
    else passes++;
    @(negedge clk);
    checks++;
    if ({x_def, y_def} !== 20'd0) $display("FAIL reset_hold got=%h exp=0", {x_def, y_def});
    else passes++;
    rst = 1'b0;
  endtask

  // Defaults: per-clock x/y/h_sync/active/pulses for one line plus, and the h_sync window.
  task automatic test_default_line();
    logic [9:0] ex, ey;
    logic eh, ea, els;
    logic prev_h;
    int low_cnt, ls_cnt;
    logic [9:0] fall_x, rise_x;
    do_reset();
    prev_h = 1'b1; low_cnt = 0; ls_cnt = 0; fall_x = '0; rise_x = '0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      ex  = 10'((k / 2) % 800);
      ey  = 10'(k / 1600);
      eh  = !(ex >= 656 && ex <= 751);
      ea  = (ex < 640) && (ey < 480);
      els = (k % 1600) == 0;
      checks++;
      if ({x_def, y_def, h_def, a_def, ls_def, fs_def} !== {ex, ey, eh, ea, els, 1'b0})
        $display("FAIL def_line k=%0d got x=%0d y=%0d h=%b a=%b ls=%b fs=%b exp x=%0d y=%0d h=%b a=%b ls=%b fs=0",
                 k, x_def, y_def, h_def, a_def, ls_def, fs_def, ex, ey, eh, ea, els);
      else passes++;
      if (prev_h && !h_def) fall_x = x_def;
      if (!prev_h && h_def) rise_x = x_def;
      if (!h_def) low_cnt++;
      if (ls_def) ls_cnt++;
      prev_h = h_def;
    end
    checks++;
    if (low_cnt != 192) $display("FAIL hsync_low_cycles got=%0d exp=192", low_cnt); else passes++;
    checks++;
    if (fall_x !== 10'd656) $display("FAIL hsync_fall_x got=%0d exp=656", fall_x); else passes++;
    checks++;
    if (rise_x !== 10'd752) $display("FAIL hsync_rise_x got=%0d exp=752", rise_x); else passes++;
    checks++;
    if (ls_cnt != 1) $display("FAIL line_start_count got=%0d exp=1", ls_cnt); else passes++;
  endtask

  // Defaults: enable hold at x=100, divider phase, suppressed tick, pulse squashing.
  task automatic test_enable();
    bit found;
    do_reset();
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (x_def == 10'd100) found = 1;
    end
    checks++;
    if (!found) $display("FAIL reach_x100 got=timeout exp=x 100"); else passes++;
    en_def = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({x_def, y_def, ls_def, fs_def} !== {10'd100, 10'd0, 2'b00})
        $display("FAIL en_hold i=%0d got x=%0d y=%0d ls=%b fs=%b exp x=100 y=0 ls=0 fs=0", i, x_def, y_def, ls_def, fs_def);
      else passes++;
    end
    en_def = 1'b1;
    @(negedge clk);
    checks++;
    if (x_def !== 10'd100) $display("FAIL en_phase1 got=%0d exp=100", x_def); else passes++;
    @(negedge clk);
    checks++;
    if (x_def !== 10'd101) $display("FAIL en_phase2 got=%0d exp=101", x_def); else passes++;
    // Divider now one short of a tick: dropping enable must defer that tick.
    @(negedge clk);
    checks++;
    if (x_def !== 10'd101) $display("FAIL pend_pre got=%0d exp=101", x_def); else passes++;
    en_def = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (x_def !== 10'd101) $display("FAIL pend_suppressed got=%0d exp=101", x_def); else passes++;
    en_def = 1'b1;
    @(negedge clk);
    checks++;
    if (x_def !== 10'd102) $display("FAIL pend_resume got=%0d exp=102", x_def); else passes++;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (ls_def) found = 1;
    end
    checks++;
    if (!found || {x_def, y_def} !== {10'd0, 10'd1})
      $display("FAIL reach_wrap got found=%0d x=%0d y=%0d exp found=1 x=0 y=1", found, x_def, y_def);
    else passes++;
    en_def = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_def, y_def, ls_def} !== {10'd0, 10'd1, 1'b0})
      $display("FAIL pulse_squash got x=%0d y=%0d ls=%b exp x=0 y=1 ls=0", x_def, y_def, ls_def);
    else passes++;
    en_def = 1'b1;
    @(negedge clk);
    checks++;
    if ({x_def, ls_def} !== {10'd0, 1'b0}) $display("FAIL pulse_resume1 got x=%0d ls=%b exp x=0 ls=0", x_def, ls_def);
    else passes++;
    @(negedge clk);
    checks++;
    if ({x_def, ls_def} !== {10'd1, 1'b0}) $display("FAIL pulse_resume2 got x=%0d ls=%b exp x=1 ls=0", x_def, ls_def);
    else passes++;
  endtask

  // H=4/1/2/1, V=3/1/1/1, HS_POL=1, DIV=1: 8-clock lines, 48-clock frames.
  task automatic test_small();
    logic [3:0] ex, ey;
    logic eh, ev, ea, els, efs;
    int last_ls, ls_per, last_fs, fs_per;
    do_reset();
    last_ls = -1; ls_per = 0; last_fs = -1; fs_per = 0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      ex  = 4'(k % 8);
      ey  = 4'((k / 8) % 6);
      eh  = (ex >= 5) && (ex <= 6);
      ev  = (ey != 4);
      ea  = (ex < 4) && (ey < 3);
      els = (k % 8) == 0;
      efs = (k % 48) == 0;
      checks++;
      if ({x_sm, y_sm, h_sm, v_sm, a_sm, ls_sm, fs_sm} !== {ex, ey, eh, ev, ea, els, efs})
        $display("FAIL small k=%0d got=%h exp=%h", k, {x_sm, y_sm, h_sm, v_sm, a_sm, ls_sm, fs_sm}, {ex, ey, eh, ev, ea, els, efs});
      else passes++;
      if (ls_sm) begin
        if (last_ls >= 0) ls_per = k - last_ls;
        last_ls = k;
      end
      if (fs_sm) begin
        if (last_fs >= 0) fs_per = k - last_fs;
        last_fs = k;
      end
    end
    checks++;
    if (ls_per != 8) $display("FAIL small_line_period got=%0d exp=8", ls_per); else passes++;
    checks++;
    if (fs_per != 48) $display("FAIL small_frame_period got=%0d exp=48", fs_per); else passes++;
  endtask

  // Default vertical timing with 12-pixel lines, DIV=2: frame is 525*12*2 clocks.
  task automatic test_mid_frame();
    logic [9:0] ex, ey;
    logic eh, ev, ea, els, efs;
    int fs_first, fs_per, fs_cnt, vs_low;
    do_reset();
    fs_first = -1; fs_per = 0; fs_cnt = 0; vs_low = 0;
    for (int k = 1; k <= 26000; k++) begin
      @(negedge clk);
      ex  = 10'((k / 2) % 12);
      ey  = 10'((k / 24) % 525);
      eh  = !(ex >= 9 && ex <= 10);
      ev  = !(ey >= 490 && ey <= 491);
      ea  = (ex < 8) && (ey < 480);
      els = (k % 24) == 0;
      efs = (k % 12600) == 0;
      checks++;
      if ({x_mid, y_mid, h_mid, v_mid, a_mid, ls_mid, fs_mid} !== {ex, ey, eh, ev, ea, els, efs})
        $display("FAIL mid k=%0d got x=%0d y=%0d h=%b v=%b a=%b ls=%b fs=%b exp x=%0d y=%0d h=%b v=%b a=%b ls=%b fs=%b",
                 k, x_mid, y_mid, h_mid, v_mid, a_mid, ls_mid, fs_mid, ex, ey, eh, ev, ea, els, efs);
      else passes++;
      if (!v_mid) vs_low++;
      if (fs_mid) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else fs_per = k - fs_first;
      end
    end
    checks++;
    if (fs_cnt != 2) $display("FAIL mid_frame_count got=%0d exp=2", fs_cnt); else passes++;
    checks++;
    if (fs_per != 12600) $display("FAIL mid_frame_period got=%0d exp=12600", fs_per); else passes++;
    checks++;
    if (vs_low != 96) $display("FAIL mid_vsync_low got=%0d exp=96", vs_low); else passes++;
  endtask

  // Asynchronous mid-frame reset, then restart from (0,0) without a pulse.
  task automatic test_reset_mid();
    bit found;
    do_reset();
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (y_mid == 10'd200 && x_mid == 10'd5) found = 1;
    end
    checks++;
    if (!found || x_def == 10'd0) $display("FAIL reach_y200 got found=%0d x_def=%0d exp found=1 x_def nonzero", found, x_def);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({x_def, y_def, h_def, v_def, a_def, ls_def, fs_def} !== {10'd0, 10'd0, 5'b11100})
      $display("FAIL async_rst_def got=%h exp=%h", {x_def, y_def, h_def, v_def, a_def, ls_def, fs_def}, {10'd0, 10'd0, 5'b11100});
    else passes++;
    checks++;
    if ({x_mid, y_mid, h_mid, v_mid, a_mid} !== {10'd0, 10'd0, 3'b111})
      $display("FAIL async_rst_mid got=%h exp=%h", {x_mid, y_mid, h_mid, v_mid, a_mid}, {10'd0, 10'd0, 3'b111});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_def, y_def, ls_def, fs_def} !== {10'd0, 10'd0, 2'b00})
      $display("FAIL restart1 got x=%0d y=%0d ls=%b fs=%b exp 0 0 0 0", x_def, y_def, ls_def, fs_def);
    else passes++;
    @(negedge clk);
    checks++;
    if ({x_def, y_def, ls_def, fs_def, x_mid, ls_mid} !== {10'd1, 10'd0, 2'b00, 10'd1, 1'b0})
      $display("FAIL restart2 got x=%0d y=%0d ls=%b fs=%b xm=%0d lsm=%b exp x=1 y=0 ls=0 fs=0 xm=1 lsm=0",
               x_def, y_def, ls_def, fs_def, x_mid, ls_mid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_enable();
    test_small();
    test_mid_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
